motor_ramp_ctrl: RTL and testbench
==================================

// Module: motor_ramp_ctrl
// PURPOSE
//  Slew-rate limiter and direction sequencer that sits directly upstream of the DC-motor PWM stage.
//  Accepts target duty/direction commands for motors A and B from the rover movement logic.
//  Drives PWM_a/PWM_b toward each target in fixed steps: soft start and stop, no overshoot.
//  Never reverses a motor while its duty is non-zero; a dead time is inserted at zero duty.
// PARAMETERS
//  STEP_DIV  250000  clk cycles per ramp tick (>=1)
//  STEP      8       duty change per tick (1..255)
//  DEADTIME  4       ticks held at duty 0 before a direction flip (>=1)
// PORTS
//  clk         in   1  system clock, 100 MHz
//  rst_n       in   1  asynchronous active-low reset
//  cmd_valid   in   1  command present
//  cmd_ready   out  1  command can be accepted
//  cmd_duty_a  in   8  target duty, motor A (0..255)
//  cmd_dir_a   in   1  target direction, motor A (0 = fwd)
//  cmd_duty_b  in   8  target duty, motor B
//  cmd_dir_b   in   1  target direction, motor B
//  estop       in   1  emergency stop, level, synchronous
//  PWM_a       out  8  current duty to PWM stage, motor A
//  PWM_b       out  8  current duty to PWM stage, motor B
//  dir_a       out  1  applied direction, motor A (to H-bridge IN pins)
//  dir_b       out  1  applied direction, motor B
//  settled     out  1  both channels at target duty and direction
// BEHAVIOUR
//  Reset (async, rst_n=0): PWM_a=PWM_b=0, dir_a=dir_b=0, targets=0/fwd, prescaler=0, both FSMs RUN,
//   cmd_ready=1, settled=1. Reset mid-ramp or mid-dead-time aborts immediately without a clock.
//  Prescaler: free-running 0..STEP_DIV-1. tick=1 for the single cycle where count==STEP_DIV-1.
//  Handshake: cmd_ready = ~estop. A command is accepted on a clk edge with cmd_valid & cmd_ready.
//   Both targets are latched together. A new command overrides the current target mid-ramp.
//   It takes effect from the next tick.
//  Target with duty 0: the latched direction is ignored and the current direction is held.
//  Per-channel FSM (A and B are independent, identical); updates happen only on tick:
//   RUN, tgt_dir==dir (or tgt_duty==0):
//    - cur<tgt: cur <= min(cur+STEP, tgt).
//    - cur>tgt: cur <= max(cur-STEP, tgt).
//    - Use 9-bit intermediates; results never wrap or pass 255/0.
//   RUN, tgt_dir!=dir:
//    - cur>0: cur <= max(cur-STEP, 0).
//    - cur==0: go to DEAD, dead_cnt <= 0.
//   DEAD: cur held 0.
//    - On each tick, dead_cnt++.
//    - On the tick where dead_cnt==DEADTIME-1: dir <= tgt_dir, go to RUN.
//    - If a new command makes tgt_dir==dir (or tgt_duty==0) while in DEAD: go to RUN on the next
//      tick with no direction change.
//   PWM_x is cur registered directly (no extra latency). dir_x changes only in DEAD, with cur==0.
//  estop=1: on the next clk edge PWM_a=PWM_b=0, targets cleared to 0, FSMs to RUN, dir held.
//   cmd_ready=0 and commands are ignored. After release, outputs stay 0 until a new command.
//  estop has priority over a command accepted on the same edge.
//  settled = both FSMs in RUN & cur==tgt & (dir==tgt_dir | tgt==0). Registered, updates 1 clk after
//   the state change.
// TESTING (bench overrides STEP_DIV=4, STEP=16, DEADTIME=2)
//  Reset, then cmd A=64 fwd -> PWM_a 16,32,48,64 on successive ticks (4 clk apart); settled=1 after 64.
//  cmd A=250 from 0 -> ...,224,240,250; never exceeds 250; settled=1.
//  A at 64 fwd, cmd A=32 rev:
//   -> PWM_a 48,32,16,0; dir_a=0 for 2 ticks at 0; then dir_a=1; then PWM_a 16,32.
//  Ramping A up, at 80 cmd A=40 fwd -> 64,48,40 (retarget down with no overshoot).
//  estop mid-ramp (A=96):
//   -> PWM_a=0 next clk; cmd_ready=0; cmd_valid pulse ignored; after release PWM_a stays 0.
//  rst_n low mid-dead-time between clk edges -> PWM=0, dir=0, settled=1 immediately.
//  Simultaneous cmd_valid & estop -> command dropped, PWM=0.

Source files
------------

// File: rtl/motor_cmd_if.sv
// Command channel from the movement logic into the motor ramp controller:
// one valid/ready handshake carrying target duty and direction for both motors.
interface motor_cmd_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_duty_a;
    logic       cmd_dir_a;
    logic [7:0] cmd_duty_b;
    logic       cmd_dir_b;

    modport master (
        output cmd_valid,
        output cmd_duty_a,
        output cmd_dir_a,
        output cmd_duty_b,
        output cmd_dir_b,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_duty_a,
        input  cmd_dir_a,
        input  cmd_duty_b,
        input  cmd_dir_b,
        output cmd_ready
    );
endinterface

// File: rtl/motor_ramp_ctrl.sv
// Slew-rate limiter and direction sequencer for two DC-motor PWM channels.
// Duty ramps in fixed steps per prescaler tick; reversal only via a dead time at zero duty.
module motor_ramp_ctrl #(
    parameter int STEP_DIV = 250000,
    parameter int STEP     = 8,
    parameter int DEADTIME = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    motor_cmd_if.slave     cmd,
    input  logic           estop,
    output logic [7:0]     PWM_a,
    output logic [7:0]     PWM_b,
    output logic           dir_a,
    output logic           dir_b,
    output logic           settled
);

    localparam int PRE_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int DEAD_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DEAD = 1'b1
    } ch_state_t;

    logic [PRE_W-1:0]  pre_r;
    logic              tick_s;
    logic              accept_s;
    logic              settled_r;

    // Index 0 is motor A, index 1 is motor B.
    logic [7:0]        cur_r        [2];
    logic              dir_r        [2];
    ch_state_t         st_r         [2];
    logic [DEAD_W-1:0] dead_cnt_r   [2];
    logic [7:0]        tgt_duty_r   [2];
    logic              tgt_dir_r    [2];

    logic [7:0]        cmd_duty_s   [2];
    logic              cmd_dir_s    [2];
    logic [8:0]        sum9_s       [2];
    logic [8:0]        tgt9_s       [2];
    logic [7:0]        ramp_up_s    [2];
    logic [7:0]        ramp_dn_s    [2];
    logic [7:0]        ramp_zero_s  [2];
    logic              same_dir_s   [2];
    logic              ch_settled_s [2];

    assign cmd_duty_s[0] = cmd.cmd_duty_a;
    assign cmd_duty_s[1] = cmd.cmd_duty_b;
    assign cmd_dir_s[0]  = cmd.cmd_dir_a;
    assign cmd_dir_s[1]  = cmd.cmd_dir_b;

    assign cmd.cmd_ready = ~estop;
    assign accept_s      = cmd.cmd_valid & ~estop;
    assign tick_s        = (pre_r == PRE_W'(STEP_DIV - 1));

    assign PWM_a   = cur_r[0];
    assign PWM_b   = cur_r[1];
    assign dir_a   = dir_r[0];
    assign dir_b   = dir_r[1];
    assign settled = settled_r;

    // Next-step duty candidates; 9-bit sums keep the clamps from wrapping past 0 or 255.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            sum9_s[ch] = {1'b0, cur_r[ch]} + 9'(STEP);
            tgt9_s[ch] = {1'b0, tgt_duty_r[ch]};
            if (sum9_s[ch] > tgt9_s[ch]) begin
                ramp_up_s[ch] = tgt_duty_r[ch];
            end else begin
                ramp_up_s[ch] = sum9_s[ch][7:0];
            end
            if ({1'b0, cur_r[ch]} > (tgt9_s[ch] + 9'(STEP))) begin
                ramp_dn_s[ch] = cur_r[ch] - 8'(STEP);
            end else begin
                ramp_dn_s[ch] = tgt_duty_r[ch];
            end
            if (cur_r[ch] > 8'(STEP)) begin
                ramp_zero_s[ch] = cur_r[ch] - 8'(STEP);
            end else begin
                ramp_zero_s[ch] = 8'd0;
            end
            same_dir_s[ch]   = (tgt_duty_r[ch] == 8'd0) || (tgt_dir_r[ch] == dir_r[ch]);
            ch_settled_s[ch] = (st_r[ch] == ST_RUN) && (cur_r[ch] == tgt_duty_r[ch]) && same_dir_s[ch];
        end
    end

    // Prescaler, target latch, per-channel ramp/dead-time FSMs and the settled flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r     <= {PRE_W{1'b0}};
            settled_r <= 1'b1;
            for (int ch = 0; ch < 2; ch++) begin
                cur_r[ch]      <= 8'd0;
                dir_r[ch]      <= 1'b0;
                st_r[ch]       <= ST_RUN;
                dead_cnt_r[ch] <= {DEAD_W{1'b0}};
                tgt_duty_r[ch] <= 8'd0;
                tgt_dir_r[ch]  <= 1'b0;
            end
        end else begin
            pre_r     <= tick_s ? {PRE_W{1'b0}} : (pre_r + PRE_W'(1'b1));
            settled_r <= ch_settled_s[0] & ch_settled_s[1];
            if (estop) begin
                // Direction is deliberately held: the bridge stays as it was, just unpowered.
                for (int ch = 0; ch < 2; ch++) begin
                    cur_r[ch]      <= 8'd0;
                    st_r[ch]       <= ST_RUN;
                    dead_cnt_r[ch] <= {DEAD_W{1'b0}};
                    tgt_duty_r[ch] <= 8'd0;
                    tgt_dir_r[ch]  <= 1'b0;
                end
            end else begin
                for (int ch = 0; ch < 2; ch++) begin
                    if (accept_s) begin
                        tgt_duty_r[ch] <= cmd_duty_s[ch];
                        tgt_dir_r[ch]  <= cmd_dir_s[ch];
                    end
                    if (tick_s) begin
                        case (st_r[ch])
                            ST_RUN: begin
                                if (same_dir_s[ch]) begin
                                    if (cur_r[ch] < tgt_duty_r[ch]) begin
                                        cur_r[ch] <= ramp_up_s[ch];
                                    end else if (cur_r[ch] > tgt_duty_r[ch]) begin
                                        cur_r[ch] <= ramp_dn_s[ch];
                                    end
                                end else if (cur_r[ch] != 8'd0) begin
                                    cur_r[ch] <= ramp_zero_s[ch];
                                end else begin
                                    st_r[ch]       <= ST_DEAD;
                                    dead_cnt_r[ch] <= {DEAD_W{1'b0}};
                                end
                            end
                            ST_DEAD: begin
                                if (same_dir_s[ch]) begin
                                    st_r[ch] <= ST_RUN;
                                end else if (dead_cnt_r[ch] == DEAD_W'(DEADTIME - 1)) begin
                                    dir_r[ch] <= tgt_dir_r[ch];
                                    st_r[ch]  <= ST_RUN;
                                end else begin
                                    dead_cnt_r[ch] <= dead_cnt_r[ch] + DEAD_W'(1'b1);
                                end
                            end
                            default: begin
                                st_r[ch] <= ST_RUN;
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Self-checking bench for motor_ramp_ctrl: directed scenarios plus a randomized run,
// all compared against a per-cycle behavioural model of the ramp/dead-time rules.
module tb_motor_ramp_ctrl;

    localparam int STEP_DIV = 4;
    localparam int STEP     = 16;
    localparam int DEADTIME = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       estop = 1'b0;
    logic [7:0] PWM_a, PWM_b;
    logic       dir_a, dir_b, settled;

    int n_vec = 0;
    int n_bad = 0;

    motor_cmd_if cmd_bus ();

    motor_ramp_ctrl #(.STEP_DIV(STEP_DIV), .STEP(STEP), .DEADTIME(DEADTIME)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cmd     (cmd_bus.slave),
        .estop   (estop),
        .PWM_a   (PWM_a),
        .PWM_b   (PWM_b),
        .dir_a   (dir_a),
        .dir_b   (dir_b),
        .settled (settled)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int cur;
        bit dir;
        bit dead;
        int left;   // dead-time ticks still to wait before the flip
    } chan_t;

    chan_t m_ch   [2];
    int    m_tgt  [2];
    bit    m_tdir [2];
    int    m_pre;
    bit    m_settled;

    function automatic chan_t chan_step(chan_t c, int tgt, bit tdir);
        chan_t n = c;
        bit    keep = (tgt == 0) || (tdir == c.dir);
        if (!c.dead) begin
            if (keep) begin
                if (c.cur < tgt)      n.cur = (c.cur + STEP > tgt) ? tgt : c.cur + STEP;
                else if (c.cur > tgt) n.cur = (c.cur - STEP < tgt) ? tgt : c.cur - STEP;
            end else if (c.cur > 0) begin
                n.cur = (c.cur - STEP < 0) ? 0 : c.cur - STEP;
            end else begin
                n.dead = 1'b1;
                n.left = DEADTIME;
            end
        end else begin
            if (keep) n.dead = 1'b0;
            else if (c.left == 1) begin
                n.dead = 1'b0;
                n.dir  = tdir;
            end else n.left = c.left - 1;
        end
        return n;
    endfunction

    function automatic bit chan_done(chan_t c, int tgt, bit tdir);
        return !c.dead && (c.cur == tgt) && ((tgt == 0) || (tdir == c.dir));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_ch[i]   <= '{0, 1'b0, 1'b0, 0};
                m_tgt[i]  <= 0;
                m_tdir[i] <= 1'b0;
            end
            m_pre     <= 0;
            m_settled <= 1'b1;
        end else begin
            m_pre     <= (m_pre == STEP_DIV - 1) ? 0 : m_pre + 1;
            m_settled <= chan_done(m_ch[0], m_tgt[0], m_tdir[0]) && chan_done(m_ch[1], m_tgt[1], m_tdir[1]);
            if (estop) begin
                for (int i = 0; i < 2; i++) begin
                    m_ch[i] <= '{0, m_ch[i].dir, 1'b0, 0};
                    m_tgt[i] <= 0;
                end
            end else begin
                if (m_pre == STEP_DIV - 1) begin
                    for (int i = 0; i < 2; i++) m_ch[i] <= chan_step(m_ch[i], m_tgt[i], m_tdir[i]);
                end
                if (cmd_bus.cmd_valid) begin
                    m_tgt[0]  <= int'(cmd_bus.cmd_duty_a);
                    m_tdir[0] <= cmd_bus.cmd_dir_a;
                    m_tgt[1]  <= int'(cmd_bus.cmd_duty_b);
                    m_tdir[1] <= cmd_bus.cmd_dir_b;
                end
            end
        end
    end

    logic [19:0] obs_s, exp_s;
    assign obs_s = {PWM_a, PWM_b, dir_a, dir_b, settled, cmd_bus.cmd_ready};
    assign exp_s = {8'(m_ch[0].cur), 8'(m_ch[1].cur), m_ch[0].dir, m_ch[1].dir, m_settled, ~estop};

    // ---------------- stimulus helpers (drive only) ----------------
    task automatic send_cmd(input logic [7:0] da, input logic ra, input logic [7:0] db, input logic rb);
        @(negedge clk);
        cmd_bus.cmd_valid  = 1'b1;
        cmd_bus.cmd_duty_a = da;
        cmd_bus.cmd_dir_a  = ra;
        cmd_bus.cmd_duty_b = db;
        cmd_bus.cmd_dir_b  = rb;
        @(negedge clk);
        cmd_bus.cmd_valid  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        estop = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_duty_a = 8'd0; cmd_bus.cmd_dir_a = 1'b0;
        cmd_bus.cmd_duty_b = 8'd0; cmd_bus.cmd_dir_b = 1'b0;
        @(negedge clk);
        n_vec++;
        if (obs_s !== 20'h00003) begin
            n_bad++;
            $display("FAIL reset_state obs=%h exp=%h", obs_s, 20'h00003);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_ramp_up();
        int seq[$];
        int last = 0;
        send_cmd(8'd64, 1'b0, 8'd0, 1'b0);
        repeat (24) begin
            @(negedge clk);
            n_vec++;
            if (obs_s !== exp_s) begin
                n_bad++;
                $display("FAIL ramp_up obs=%h exp=%h", obs_s, exp_s);
            end
            if (int'(PWM_a) != last) begin
                last = int'(PWM_a);
                seq.push_back(last);
            end
        end
        n_vec++;
        if (seq.size() != 4 || seq[0] != 16 || seq[1] != 32 || seq[2] != 48 || seq[3] != 64) begin
            n_bad++;
            $display("FAIL ramp_up_seq got=%p exp=16,32,48,64", seq);
        end
        n_vec++;
        if ({PWM_a, settled} !== {8'd64, 1'b1}) begin
            n_bad++;
            $display("FAIL ramp_up_final pwm=%0d settled=%b exp 64/1", PWM_a, settled);
        end
    endtask

    task automatic test_ramp_250();
        do_reset();
        send_cmd(8'd250, 1'b0, 8'd0, 1'b0);
        repeat (90) begin
            @(negedge clk);
            n_vec++;
            if (obs_s !== exp_s || PWM_a > 8'd250) begin
                n_bad++;
                $display("FAIL ramp_250 obs=%h exp=%h", obs_s, exp_s);
            end
        end
        n_vec++;
        if ({PWM_a, settled} !== {8'd250, 1'b1}) begin
            n_bad++;
            $display("FAIL ramp_250_final pwm=%0d settled=%b exp 250/1", PWM_a, settled);
        end
    endtask

    task automatic test_reverse();
        logic prev_dir;
        logic [7:0] prev_pwm;
        do_reset();
        send_cmd(8'd64, 1'b0, 8'd0, 1'b0);
        repeat (24) @(negedge clk);
        send_cmd(8'd32, 1'b1, 8'd0, 1'b0);
        prev_dir = dir_a;
        prev_pwm = PWM_a;
        repeat (60) begin
            @(negedge clk);
            n_vec++;
            if (obs_s !== exp_s || (dir_a !== prev_dir && prev_pwm !== 8'd0)) begin
                n_bad++;
                $display("FAIL reverse obs=%h exp=%h", obs_s, exp_s);
            end
            prev_dir = dir_a;
            prev_pwm = PWM_a;
        end
        n_vec++;
        if ({PWM_a, dir_a} !== {8'd32, 1'b1}) begin
            n_bad++;
            $display("FAIL reverse_final pwm=%0d dir=%b exp 32/1", PWM_a, dir_a);
        end
    endtask

    task automatic test_retarget();
        int seq[$];
        int last;
        int guard = 0;
        do_reset();
        send_cmd(8'd200, 1'b0, 8'd0, 1'b0);
        while (m_ch[0].cur != 80 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if (PWM_a !== 8'd80) begin
            n_bad++;
            $display("FAIL retarget_reach pwm=%0d exp=80 waited=%0d", PWM_a, guard);
        end
        last = 80;
        send_cmd(8'd40, 1'b0, 8'd0, 1'b0);
        repeat (30) begin
            @(negedge clk);
            n_vec++;
            if (obs_s !== exp_s) begin
                n_bad++;
                $display("FAIL retarget obs=%h exp=%h", obs_s, exp_s);
            end
            if (int'(PWM_a) != last) begin
                last = int'(PWM_a);
                seq.push_back(last);
            end
        end
        n_vec++;
        if (seq.size() != 3 || seq[0] != 64 || seq[1] != 48 || seq[2] != 40) begin
            n_bad++;
            $display("FAIL retarget_seq got=%p exp=64,48,40", seq);
        end
    endtask

    task automatic test_estop();
        int guard = 0;
        do_reset();
        send_cmd(8'd200, 1'b0, 8'd0, 1'b0);
        while (m_ch[0].cur != 96 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        estop = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({PWM_a, cmd_bus.cmd_ready} !== {8'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL estop_now pwm=%0d ready=%b exp 0/0", PWM_a, cmd_bus.cmd_ready);
        end
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_duty_a = 8'd150;
        @(negedge clk);
        cmd_bus.cmd_valid = 1'b0;
        estop = 1'b0;
        repeat (30) begin
            @(negedge clk);
            n_vec++;
            if (obs_s !== exp_s) begin
                n_bad++;
                $display("FAIL estop_release obs=%h exp=%h", obs_s, exp_s);
            end
        end
        n_vec++;
        if ({PWM_a, settled} !== {8'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL estop_final pwm=%0d settled=%b exp 0/1", PWM_a, settled);
        end
    endtask

    task automatic test_reset_mid_dead();
        int guard = 0;
        do_reset();
        send_cmd(8'd64, 1'b1, 8'd0, 1'b0);
        repeat (50) begin
            @(negedge clk);
            n_vec++;
            if (obs_s !== exp_s) begin
                n_bad++;
                $display("FAIL rev_setup obs=%h exp=%h", obs_s, exp_s);
            end
        end
        send_cmd(8'd64, 1'b0, 8'd0, 1'b0);
        while (!m_ch[0].dead && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if ({PWM_a, dir_a, settled} !== {8'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL dead_pre pwm=%0d dir=%b settled=%b exp 0/1/0", PWM_a, dir_a, settled);
        end
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({PWM_a, PWM_b, dir_a, dir_b, settled} !== {8'd0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL async_reset pwm=%0d/%0d dir=%b/%b settled=%b exp 0/0 0/0 1",
                     PWM_a, PWM_b, dir_a, dir_b, settled);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_estop_with_cmd();
        do_reset();
        send_cmd(8'd100, 1'b0, 8'd100, 1'b1);
        repeat (12) @(negedge clk);
        estop = 1'b1;
        cmd_bus.cmd_valid  = 1'b1;
        cmd_bus.cmd_duty_a = 8'd200;
        cmd_bus.cmd_duty_b = 8'd200;
        @(negedge clk);
        estop = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        repeat (30) begin
            @(negedge clk);
            n_vec++;
            if (obs_s !== exp_s) begin
                n_bad++;
                $display("FAIL estop_cmd obs=%h exp=%h", obs_s, exp_s);
            end
        end
        n_vec++;
        if ({PWM_a, PWM_b} !== {8'd0, 8'd0}) begin
            n_bad++;
            $display("FAIL estop_cmd_final pwm=%0d/%0d exp 0/0", PWM_a, PWM_b);
        end
    endtask

    task automatic test_random();
        do_reset();
        repeat (800) begin
            @(negedge clk);
            n_vec++;
            if (obs_s !== exp_s) begin
                n_bad++;
                $display("FAIL random obs=%h exp=%h", obs_s, exp_s);
            end
            cmd_bus.cmd_valid  = ($urandom_range(0, 5) == 0);
            cmd_bus.cmd_duty_a = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            cmd_bus.cmd_dir_a  = 1'($urandom_range(0, 1));
            cmd_bus.cmd_duty_b = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            cmd_bus.cmd_dir_b  = 1'($urandom_range(0, 1));
            if (estop) estop = ($urandom_range(0, 3) != 0);
            else       estop = ($urandom_range(0, 80) == 0);
        end
        cmd_bus.cmd_valid = 1'b0;
        estop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_250();
        test_reverse();
        test_retarget();
        test_estop();
        test_reset_mid_dead();
        test_estop_with_cmd();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
